// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns chip-select framed SPI byte streams into register-bank
// write/read strobes. First byte of a frame is the command (bit7=1 write,
// bit7=0 read, low ADDR_W bits = start address); the rest is a data burst
// with auto-incrementing address. Reads prefetch the register onto
// miso_data_in so the next byte request finds it ready.
module spi_reg_bridge #(
  parameter int          ADDR_W  = 7,
  parameter logic [7:0]  TA_BYTE = 8'h00
) (
  input  logic              iCLK,
  input  logic              RST,
  input  logic              start_of_transfer,
  input  logic              end_of_transfer,
  input  logic [7:0]        mosi_data_out,
  input  logic              mosi_data_ready,
  input  logic              miso_data_request,
  output logic [7:0]        miso_data_in,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              xfer_active
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WR   = 2'd2,
    S_RD   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                cap_q, cap_d;     // reg_rdata is valid this cycle
  logic [7:0]          miso_q, miso_d;
  logic                xfer_q, xfer_d;
  logic                kill;

  // A frame boundary landing in the strobe cycle itself must still cancel
  // the strobe, so the registered strobe is masked by the live pulses.
  assign kill        = start_of_transfer | end_of_transfer;
  assign reg_we      = we_q & ~kill;
  assign reg_re      = re_q & ~kill;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign miso_data_in = miso_q;
  assign xfer_active = xfer_q;

  // Next-state: frame control first (start beats end), then burst handling.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    cap_d   = 1'b0;
    miso_d  = miso_q;
    xfer_d  = xfer_q;
    if (start_of_transfer) begin
      state_d = S_CMD;
      xfer_d  = 1'b1;
      miso_d  = TA_BYTE;
    end else if (end_of_transfer) begin
      state_d = S_IDLE;
      xfer_d  = 1'b0;
      miso_d  = TA_BYTE;
    end else begin
      // Pointer advances at the end of each issued strobe cycle.
      if (reg_we || reg_re) ptr_d = ptr_q + ADDR_W'(1);
      if (reg_re)           cap_d = 1'b1;
      if (cap_q)            miso_d = reg_rdata;
      if (mosi_data_ready) begin
        case (state_q)
          S_CMD: begin
            ptr_d = mosi_data_out[ADDR_W-1:0];
            if (mosi_data_out[7]) begin
              state_d = S_WR;
            end else begin
              state_d = S_RD;
              re_d    = 1'b1;
              addr_d  = mosi_data_out[ADDR_W-1:0];
            end
          end
          S_WR: begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = mosi_data_out;
          end
          S_RD: begin
            re_d   = 1'b1;
            addr_d = ptr_q;
          end
          default: ;
        endcase
      end
      // Outside a read burst the shifter always gets the turnaround byte.
      if (miso_data_request && state_q != S_RD) miso_d = TA_BYTE;
    end
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge iCLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      cap_q   <= 1'b0;
      miso_q  <= TA_BYTE;
      xfer_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      cap_q   <= cap_d;
      miso_q  <= miso_d;
      xfer_q  <= xfer_d;
    end
  end

endmodule
